intr_gen: RTL

//  Memory-mapped interrupt source driving the CSR unit's t_intr/e_intr inputs.

---
 rtl/intr_gen.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/intr_gen.sv
`default_nettype none
// ============================================================================
// Module  : intr_gen
// Brief   : Memory-mapped machine timer (mtime/mtimecmp) and synchronised
//           external IRQ source feeding the CSR unit's t_intr/e_intr inputs.
//           Optional macro MTIME_LATCH_EN adds a tear-free mtime_hi shadow.
// Rev     : 1.0  initial release
// ============================================================================
module intr_gen #(
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
  parameter int unsigned PRESCALE    = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_wr,
  input  logic        mem_rd,
  output logic [31:0] rdata,
  input  logic        ext_irq,
  input  logic        intr_ack,
  output logic        t_intr,
  output logic        e_intr
);

  localparam int unsigned       c_PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PS_W-1:0] c_PS_MAX = c_PS_W'(PRESCALE - 1);

  localparam logic [2:0] c_OFF_MTIME_LO = 3'd0;
  localparam logic [2:0] c_OFF_MTIME_HI = 3'd1;
  localparam logic [2:0] c_OFF_CMP_LO   = 3'd2;
  localparam logic [2:0] c_OFF_CMP_HI   = 3'd3;
  localparam logic [2:0] c_OFF_CTRL     = 3'd4;
  localparam logic [2:0] c_OFF_STATUS   = 3'd5;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic       w_sel;
  logic [2:0] w_off;
  logic       w_wr;
  logic       w_rd;
  logic       w_wr_mtlo;
  logic       w_wr_mthi;
  logic       w_wr_cmplo;
  logic       w_wr_cmphi;
  logic       w_wr_ctrl;
  logic       w_wr_stat;
  logic       w_unused;

  assign w_sel      = (addr[31:5] == BASE_ADDR[31:5]);
  assign w_off      = addr[4:2];
  assign w_wr       = mem_wr & w_sel;
  assign w_rd       = mem_rd & w_sel;
  assign w_wr_mtlo  = w_wr & (w_off == c_OFF_MTIME_LO);
  assign w_wr_mthi  = w_wr & (w_off == c_OFF_MTIME_HI);
  assign w_wr_cmplo = w_wr & (w_off == c_OFF_CMP_LO);
  assign w_wr_cmphi = w_wr & (w_off == c_OFF_CMP_HI);
  assign w_wr_ctrl  = w_wr & (w_off == c_OFF_CTRL);
  assign w_wr_stat  = w_wr & (w_off == c_OFF_STATUS);
  assign w_unused   = ^addr[1:0];

  // --------------------------------------------------------------------------
  // Control register
  // --------------------------------------------------------------------------
  logic [2:0] r_ctrl;
  logic       w_timer_en;
  logic       w_ext_en;
  logic       w_edge_mode;

  assign w_timer_en  = r_ctrl[0];
  assign w_ext_en    = r_ctrl[1];
  assign w_edge_mode = r_ctrl[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_ctrl <= 3'b000;
    else if (w_wr_ctrl) r_ctrl <= wdata[2:0];
  end

  // --------------------------------------------------------------------------
  // Machine timer
  // --------------------------------------------------------------------------
  logic [c_PS_W-1:0] r_presc;
  logic [63:0]       r_mtime;
  logic [63:0]       r_mtimecmp;
  logic              w_tick;
  logic              w_t_pend;
  logic              r_t_intr;

  assign w_tick = w_timer_en & (r_presc == c_PS_MAX);

  // A software write to either mtime half restarts the tick period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_presc <= '0;
    else if (w_wr_mtlo || w_wr_mthi)  r_presc <= '0;
    else if (w_timer_en)              r_presc <= w_tick ? '0 : r_presc + c_PS_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_mtime         <= 64'd0;
    else if (w_wr_mtlo) r_mtime[31:0]   <= wdata;
    else if (w_wr_mthi) r_mtime[63:32]  <= wdata;
    else if (w_tick)    r_mtime         <= r_mtime + 64'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      if (w_wr_cmplo) r_mtimecmp[31:0]  <= wdata;
      if (w_wr_cmphi) r_mtimecmp[63:32] <= wdata;
    end
  end

  assign w_t_pend = w_timer_en & (r_mtime >= r_mtimecmp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_t_intr <= 1'b0;
    else     r_t_intr <= w_t_pend;
  end

  // --------------------------------------------------------------------------
  // External interrupt
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_irq_s;
  logic                   r_irq_d;
  logic                   r_e_edge;
  logic                   w_e_set;
  logic                   w_e_clr;
  logic                   w_e_pend;
  logic                   r_e_intr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], ext_irq};
  end

  assign w_irq_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_irq_d <= 1'b0;
    else     r_irq_d <= w_irq_s;
  end

  assign w_e_set = w_edge_mode & w_irq_s & ~r_irq_d;
  assign w_e_clr = intr_ack | (w_wr_stat & wdata[1]);

  // Set has priority so an edge arriving with an ack is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_e_edge <= 1'b0;
    else if (w_e_set) r_e_edge <= 1'b1;
    else if (w_e_clr) r_e_edge <= 1'b0;
  end

  assign w_e_pend = w_edge_mode ? r_e_edge : w_irq_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_e_intr <= 1'b0;
    else     r_e_intr <= w_ext_en & w_e_pend;
  end

  assign t_intr = r_t_intr;
  assign e_intr = r_e_intr;

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  logic [31:0] w_mthi_rd;

`ifdef MTIME_LATCH_EN
  logic [31:0] r_mtime_shadow;

  // Reading mtime_lo freezes the upper word so a following hi read matches it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_mtime_shadow <= 32'd0;
    else if (w_rd && (w_off == c_OFF_MTIME_LO)) r_mtime_shadow <= r_mtime[63:32];
  end

  assign w_mthi_rd = r_mtime_shadow;
`else
  assign w_mthi_rd = r_mtime[63:32];
`endif

  always_comb begin
    rdata = 32'h0;
    if (w_rd) begin
      case (w_off)
        c_OFF_MTIME_LO: rdata = r_mtime[31:0];
        c_OFF_MTIME_HI: rdata = w_mthi_rd;
        c_OFF_CMP_LO:   rdata = r_mtimecmp[31:0];
        c_OFF_CMP_HI:   rdata = r_mtimecmp[63:32];
        c_OFF_CTRL:     rdata = {29'd0, r_ctrl};
        c_OFF_STATUS:   rdata = {30'd0, w_e_pend, w_t_pend};
        default:        rdata = 32'h0;
      endcase
    end
  end

endmodule
`default_nettype wire
